// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Purpose  : Instruction-fetch stage with a prefetch FIFO and PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              main_memory_instr_addr,
    input  logic [31:0]              main_memory_instr,
    output logic                     main_memory_instr_req,
    input  logic                     main_memory_instr_ack,
    output logic [31:0]              fetch_instr,
    output logic [31:0]              pc,
    input  logic                     writeback_change_pc,
    input  logic [31:0]              writeback_next_pc,
    input  logic                     execute_change_pc,
    input  logic [31:0]              execute_next_pc,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     next_clk_en,
    output logic [$clog2(DEPTH):0]   buffer_level
);

    localparam int unsigned c_PTR_W   = $clog2(DEPTH);
    localparam int unsigned c_LVL_W   = c_PTR_W + 1;
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_LVL_W-1:0] c_DEPTH = c_LVL_W'(DEPTH);

    typedef enum logic [c_STATE_W-1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_addr;
    logic                r_req;
    logic [31:0]         r_fetch_instr;
    logic [31:0]         r_pc;
    logic                r_next_clk_en;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [31:0]         r_fifo_instr [DEPTH];
    logic [31:0]         r_fifo_pc    [DEPTH];

    logic                w_redirect;
    logic [31:0]         w_target;
    logic                w_hold;
    logic                w_push;
    logic                w_pop;
    logic [c_LVL_W-1:0]  w_level_next;
    logic [31:0]         w_fetch_pc_next;
    logic                w_room;

    always_comb begin
        w_redirect      = writeback_change_pc | execute_change_pc;
        w_target        = (writeback_change_pc ? writeback_next_pc : execute_next_pc)
                          & 32'hFFFF_FFFC;
        // A pending request with no ack keeps req/addr frozen.
        w_hold          = r_req & ~main_memory_instr_ack;
        w_push          = r_req & main_memory_instr_ack & ~w_redirect
                          & (r_state != ST_DISCARD);
        w_pop           = ~w_redirect & ~flush & ~stall & (r_level != '0);
        w_level_next    = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
        w_fetch_pc_next = w_push ? (r_fetch_pc + 32'd4) : r_fetch_pc;
        w_room          = (w_level_next < c_DEPTH);
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= main_memory_instr;
            r_fifo_pc[r_wr_ptr]    <= r_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= PC_RESET;
            r_addr        <= PC_RESET;
            r_req         <= 1'b0;
            r_fetch_instr <= NOP_INSTR;
            r_pc          <= PC_RESET;
            r_next_clk_en <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
        end else begin
            if (w_redirect || flush) begin
                r_next_clk_en <= 1'b0;
            end else if (w_pop) begin
                r_fetch_instr <= r_fifo_instr[r_rd_ptr];
                r_pc          <= r_fifo_pc[r_rd_ptr];
                r_next_clk_en <= 1'b1;
            end else if (!stall) begin
                r_next_clk_en <= 1'b0;
            end

            if (w_redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_level <= w_level_next;
            end

            // The stale response of an unacked request is drained in DISCARD.
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                if (w_hold) begin
                    r_state <= ST_DISCARD;
                end else begin
                    r_req   <= 1'b1;
                    r_addr  <= w_target;
                    r_state <= ST_FETCH;
                end
            end else begin
                r_fetch_pc <= w_fetch_pc_next;
                if (!w_hold) begin
                    r_addr <= w_fetch_pc_next;
                    if (w_room) begin
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end else begin
                        r_req   <= 1'b0;
                        r_state <= ST_FULL;
                    end
                end
            end
        end
    end

    assign main_memory_instr_addr = r_addr;
    assign main_memory_instr_req  = r_req;
    assign fetch_instr            = r_fetch_instr;
    assign pc                     = r_pc;
    assign next_clk_en            = r_next_clk_en;
    assign buffer_level           = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch
// Purpose  : Directed vector bench for fetch_prefetch, plus wrap-around DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;

    logic [31:0] mm_addr, mm_instr, fetch_instr, pc, ex_pc, wb_pc;
    logic        mm_req, mm_ack, ex_chg, wb_chg, stall, flush, nce;
    logic [2:0]  level;

    logic [31:0] mm_addr2, mm_instr2, fetch_instr2, pc2;
    logic        mm_req2, nce2;
    logic [1:0]  level2;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign mm_instr  = mem_word(mm_addr);
    assign mm_instr2 = mem_word(mm_addr2);

    fetch_prefetch dut (
        .clk                    (clk),
        .rst                    (rst),
        .main_memory_instr_addr (mm_addr),
        .main_memory_instr      (mm_instr),
        .main_memory_instr_req  (mm_req),
        .main_memory_instr_ack  (mm_ack),
        .fetch_instr            (fetch_instr),
        .pc                     (pc),
        .writeback_change_pc    (wb_chg),
        .writeback_next_pc      (wb_pc),
        .execute_change_pc      (ex_chg),
        .execute_next_pc        (ex_pc),
        .stall                  (stall),
        .flush                  (flush),
        .next_clk_en            (nce),
        .buffer_level           (level)
    );

    fetch_prefetch #(.PC_RESET(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk                    (clk),
        .rst                    (rst),
        .main_memory_instr_addr (mm_addr2),
        .main_memory_instr      (mm_instr2),
        .main_memory_instr_req  (mm_req2),
        .main_memory_instr_ack  (1'b1),
        .fetch_instr            (fetch_instr2),
        .pc                     (pc2),
        .writeback_change_pc    (1'b0),
        .writeback_next_pc      (32'h0),
        .execute_change_pc      (1'b0),
        .execute_next_pc        (32'h0),
        .stall                  (1'b0),
        .flush                  (1'b0),
        .next_clk_en            (nce2),
        .buffer_level           (level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack, stall, flush, ex_chg;
        logic [31:0] ex_pc;
        logic        wb_chg;
        logic [31:0] wb_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_nce;
        logic [31:0] e_pc;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a, input logic s, input logic f,
                       input logic xc, input logic [31:0] xp,
                       input logic wc, input logic [31:0] wp,
                       input logic er, input logic [31:0] ea,
                       input logic en, input logic [31:0] ep, input logic [2:0] el);
        vec_t v;
        v.ack = a; v.stall = s; v.flush = f;
        v.ex_chg = xc; v.ex_pc = xp; v.wb_chg = wc; v.wb_pc = wp;
        v.e_req = er; v.e_addr = ea; v.e_nce = en; v.e_pc = ep; v.e_lvl = el;
        vecs.push_back(v);
    endtask

    task automatic add_n(input logic a, input logic s, input logic f,
                         input logic er, input logic [31:0] ea,
                         input logic en, input logic [31:0] ep, input logic [2:0] el);
        add(a, s, f, 1'b0, 32'h0, 1'b0, 32'h0, er, ea, en, ep, el);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // ack / stall / flush ; expected req, addr, next_clk_en, pc, level
        add_n(1,0,0, 1,32'h0,   0,32'h0, 0);
        add_n(1,0,0, 1,32'h4,   0,32'h0, 1);
        add_n(1,0,0, 1,32'h8,   1,32'h0, 1);
        add_n(1,0,0, 1,32'hC,   1,32'h4, 1);
        add_n(1,0,0, 1,32'h10,  1,32'h8, 1);
        add_n(1,1,0, 1,32'h14,  1,32'h8, 2);
        add_n(1,1,0, 1,32'h18,  1,32'h8, 3);
        add_n(1,1,0, 0,32'h0,   1,32'h8, 4);
        for (int k = 0; k < 7; k++) add_n(1,1,0, 0,32'h0, 1,32'h8, 4);
        add_n(1,0,0, 1,32'h1C,  1,32'hC,  3);
        add_n(1,0,0, 1,32'h20,  1,32'h10, 3);
        add_n(0,0,1, 1,32'h20,  0,32'h10, 3);
        add_n(0,0,0, 1,32'h20,  1,32'h14, 2);
        add_n(0,0,0, 1,32'h20,  1,32'h18, 1);
        add_n(0,0,0, 1,32'h20,  1,32'h1C, 0);
        add_n(0,0,0, 1,32'h20,  0,32'h1C, 0);
        // execute redirect while a request is pending
        add  (0,0,0, 1,32'h200, 0,32'h0, 1,32'h20,  0,32'h1C, 0);
        add_n(0,0,0, 1,32'h20,  0,32'h1C,  0);
        add_n(1,0,0, 1,32'h200, 0,32'h1C,  0);
        add_n(1,0,0, 1,32'h204, 0,32'h1C,  1);
        add_n(0,0,0, 1,32'h204, 1,32'h200, 0);
        // simultaneous redirects, then an unaligned writeback target
        add  (1,0,0, 1,32'h100, 1,32'h800, 1,32'h800, 0,32'h200, 0);
        add  (0,0,0, 0,32'h0,   1,32'h803, 1,32'h800, 0,32'h200, 0);
        add_n(1,0,0, 1,32'h800, 0,32'h200, 0);
        add_n(1,0,0, 1,32'h804, 0,32'h200, 1);
        add_n(1,0,0, 1,32'h808, 1,32'h800, 1);
        // a second redirect while discarding only retargets
        add  (0,0,0, 1,32'h300, 0,32'h0, 1,32'h808, 0,32'h800, 0);
        add  (0,0,0, 1,32'h400, 0,32'h0, 1,32'h808, 0,32'h800, 0);
        add_n(1,0,0, 1,32'h400, 0,32'h800, 0);
        add_n(1,0,0, 1,32'h404, 0,32'h800, 1);
        add_n(1,0,0, 1,32'h408, 1,32'h400, 1);

        rst = 1'b0; mm_ack = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_chg = 1'b0; ex_pc = '0; wb_chg = 1'b0; wb_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req",   {31'b0, mm_req}, 32'h0);
        chk("reset addr",  mm_addr,         32'h0);
        chk("reset instr", fetch_instr,     c_NOP);
        chk("reset pc",    pc,              32'h0);
        chk("reset nce",   {31'b0, nce},    32'h0);
        chk("reset level", {29'b0, level},  32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            mm_ack = vecs[i].ack;   stall  = vecs[i].stall;  flush = vecs[i].flush;
            ex_chg = vecs[i].ex_chg; ex_pc = vecs[i].ex_pc;
            wb_chg = vecs[i].wb_chg; wb_pc = vecs[i].wb_pc;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d req", i), {31'b0, mm_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("row%0d addr", i), mm_addr, vecs[i].e_addr);
            chk($sformatf("row%0d nce", i),   {31'b0, nce},   {31'b0, vecs[i].e_nce});
            chk($sformatf("row%0d pc", i),    pc,             vecs[i].e_pc);
            chk($sformatf("row%0d level", i), {29'b0, level}, {29'b0, vecs[i].e_lvl});
            if (vecs[i].e_nce)
                chk($sformatf("row%0d instr", i), fetch_instr, mem_word(vecs[i].e_pc));
        end
        mm_ack = 1'b0; stall = 1'b0; flush = 1'b0; ex_chg = 1'b0; wb_chg = 1'b0;

        // Reset in the middle of a transaction, asserted away from the edge.
        rst = 1'b0;
        #1;
        chk("midreset req",   {31'b0, mm_req}, 32'h0);
        chk("midreset addr",  mm_addr,         32'h0);
        chk("midreset instr", fetch_instr,     c_NOP);
        chk("midreset pc",    pc,              32'h0);
        chk("midreset nce",   {31'b0, nce},    32'h0);
        chk("midreset level", {29'b0, level},  32'h0);
        chk("wrap reset addr", mm_addr2,       32'hFFFF_FFF8);
        chk("wrap reset pc",   pc2,            32'hFFFF_FFF8);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Wrap-around instance with ack tied high.
        @(posedge clk); #1;
        chk("wrap e1 req",  {31'b0, mm_req2}, 32'h1);
        chk("wrap e1 addr", mm_addr2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("wrap e2 addr", mm_addr2, 32'hFFFF_FFFC);
        chk("wrap e2 nce",  {31'b0, nce2}, 32'h0);
        @(posedge clk); #1;
        chk("wrap e3 addr", mm_addr2, 32'h0000_0000);
        chk("wrap e3 nce",  {31'b0, nce2}, 32'h1);
        chk("wrap e3 pc",   pc2, 32'hFFFF_FFF8);
        chk("wrap e3 instr", fetch_instr2, mem_word(32'hFFFF_FFF8));
        @(posedge clk); #1;
        chk("wrap e4 addr", mm_addr2, 32'h0000_0004);
        chk("wrap e4 pc",   pc2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap e5 pc",   pc2, 32'h0000_0000);
        chk("wrap e5 level", {30'b0, level2}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
